// File: rtl/queue_arbiter_ctrl.sv
// Two-requester round-robin arbitrated circular queue with a single dequeue consumer.
// Optional macro QARB_DROP_CNT_EN adds an 8-bit saturating DropCount output.
module queue_arbiter_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             EnqReq0,
    input  logic [WIDTH-1:0] EnqData0,
    input  logic             EnqReq1,
    input  logic [WIDTH-1:0] EnqData1,
    output logic             EnqGnt0,
    output logic             EnqGnt1,
    output logic             MuxSelect,
    input  logic             DeqReq,
    output logic [WIDTH-1:0] DeqData,
    output logic             DeqValid,
    output logic             Full,
    output logic             Empty,
`ifdef QARB_DROP_CNT_EN
    output logic [7:0]       DropCount,
`endif
    output logic [AW:0]      Count
);

    typedef enum logic {
        PRIO_REQ0 = 1'b0,
        PRIO_REQ1 = 1'b1
    } prio_t;

    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [AW:0]      count;
    prio_t            prio;
    logic [WIDTH-1:0] wr_data;
    logic             enq;
    logic             deq;

    assign Count = count;
    assign Full  = (count == FULL_COUNT);
    assign Empty = (count == '0);

    // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
    always_comb begin
        EnqGnt0 = 1'b0;
        EnqGnt1 = 1'b0;
        if (!Full) begin
            if (EnqReq0 && EnqReq1) begin
                EnqGnt0 = (prio == PRIO_REQ0);
                EnqGnt1 = (prio == PRIO_REQ1);
            end else begin
                EnqGnt0 = EnqReq0;
                EnqGnt1 = EnqReq1;
            end
        end
    end

    assign MuxSelect = EnqGnt1;
    assign wr_data   = MuxSelect ? EnqData1 : EnqData0;
    assign enq       = EnqGnt0 | EnqGnt1;
    assign deq       = DeqReq & ~Empty;

    // NOTE: storage has no reset; head/tail/count define which entries are meaningful.
    always_ff @(posedge Clock) begin
        if (enq) begin
            mem[tail] <= wr_data;
        end
    end

    // NOTE: registered state uses non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            prio     <= PRIO_REQ0;
            DeqData  <= '0;
            DeqValid <= 1'b0;
        end else begin
            DeqValid <= deq;
            if (enq) begin
                tail <= tail + PTR_ONE;
                prio <= EnqGnt1 ? PRIO_REQ0 : PRIO_REQ1;
            end
            if (deq) begin
                DeqData <= mem[head];
                head    <= head + PTR_ONE;
            end
            case ({enq, deq})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef QARB_DROP_CNT_EN
    // Counts edges on which some requester was refused purely because the queue was full.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            DropCount <= '0;
        end else if (Full && (EnqReq0 || EnqReq1) && (DropCount != 8'hFF)) begin
            DropCount <= DropCount + 8'd1;
        end
    end
`endif

endmodule

// File: doc/queue_arbiter_ctrl.md
Name: queue_arbiter_ctrl

Overview:
Arbitrated circular queue with two enqueue requesters and one dequeue consumer.
- The two producers share the single queue write port through a 2:1 data mux.
- This block generates the mux select, grants, head/tail pointers, occupancy and flags.
- Storage is an internal register array.

Parameters:
WIDTH, 8, data width of each entry and each requester's data bus
DEPTH, 8, number of queue entries; power of two, >= 2
AW, 3, pointer width; must equal log2(DEPTH)

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
EnqReq0  input  1  requester 0 wants to enqueue EnqData0
EnqData0  input  WIDTH  requester 0 data
EnqReq1  input  1  requester 1 wants to enqueue EnqData1
EnqData1  input  WIDTH  requester 1 data
EnqGnt0  output  1  requester 0 granted this cycle (combinational)
EnqGnt1  output  1  requester 1 granted this cycle (combinational)
MuxSelect  output  1  write-data mux select: 0 = EnqData0, 1 = EnqData1
DeqReq  input  1  consumer requests one entry
DeqData  output  WIDTH  registered dequeued entry
DeqValid  output  1  DeqData valid; one-cycle pulse
Full  output  1  Count == DEPTH
Empty  output  1  Count == 0
Count  output  AW+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (synchronous, Reset=1 at a rising edge):
  - Head, tail and Count go to 0, so Empty=1 and Full=0.
  - DeqData=0, DeqValid=0.
  - Priority pointer goes to 0, so requester 0 is favoured first.
  - Storage contents are don't-care.
  - Reset during any operation discards all queue contents and any pending enq/deq that cycle.
- Arbitration (combinational, from current state):
  - No grant is issued when Full=1.
  - If exactly one EnqReq is high and the queue is not full, that requester is granted.
  - If both are high and the queue is not full, the requester indicated by the priority pointer is granted.
  - At most one grant per cycle.
  - MuxSelect = 1 when EnqGnt1, else 0. MuxSelect is 0 when idle.
- Round-robin:
  - On a clock edge with a grant to requester k, the priority pointer becomes (1-k).
  - With no grant, the pointer holds.
  - A lone requester may be granted on consecutive cycles.
- Enqueue: on a granted edge, mem[tail] <= mux output, and tail <= tail+1 modulo DEPTH (natural AW-bit wrap).
- Dequeue:
  - DeqReq with Empty=0 is accepted.
  - Accepted edge: DeqData <= mem[head], head <= head+1 modulo DEPTH, DeqValid=1 for the following cycle.
  - Non-accepted edge: DeqValid=0 and DeqData holds its last value.
  - DeqReq while Empty=1 is ignored, with no underflow.
- Count update:
  - Enqueue only: +1.
  - Dequeue only: -1.
  - Both in the same edge: unchanged.
- Simultaneous events:
  - When Full, an enqueue and an accepted dequeue in the same cycle → dequeue only. The enqueue is denied because the grant uses the pre-edge Full.
  - When Empty, an enqueue and a DeqReq in the same cycle → enqueue only. There is no bypass; the entry is readable next cycle.
- Latency:
  - Enqueued data is visible to a dequeue accepted on the following edge at the earliest.
  - DeqData appears one cycle after DeqReq is accepted.
- Flags Full and Empty are decoded from the registered Count.

Optional Feature:
Macro QARB_DROP_CNT_EN.
- Defined:
  - Adds output DropCount (8 bits, reset 0).
  - DropCount increments by 1 on each edge where Full=1 and (EnqReq0|EnqReq1)=1.
  - It saturates at 255.
  - It is cleared only by Reset.
- Not defined:
  - The port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset then idle → Count=0, Empty=1, Full=0, DeqValid=0, EnqGnt0=EnqGnt1=0, MuxSelect=0.
- Both requesters hold EnqReq for 4 cycles with EnqData0=0xA0+n and EnqData1=0xB0+n; then dequeue 4 → grants alternate 0,1,0,1 and DeqData sequence is 0xA0,0xB1,0xA2,0xB3.
- Requester 0 alone fills DEPTH=8 entries → Full=1 after 8th edge, Count=8, 9th EnqReq0 gets no grant; with QARB_DROP_CNT_EN, DropCount=1 after that edge.
- Full queue, EnqReq1 and DeqReq together → EnqGnt1=0, DeqValid=1 next cycle, Count=7; next cycle EnqGnt1=1 and Count returns to 8.
- Push 10 and pop 10 interleaved (one enq + one deq per cycle after the first enq) → Count stays 1, data returned in order, pointers wrap past 7 to 0 without loss.
- Empty queue, DeqReq=1 → DeqValid=0, Count=0; assert Reset mid-fill at Count=5 → next cycle Count=0, Empty=1, and a later dequeue returns only data written after reset.
